action_selector: RTL and testbench
==================================

ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 Parameter LFSR_SEED, default 16'hACE1, nonzero seed loaded into the exploration LFSR at reset.
REQ-002 Ports, in order:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start_valid  input  1  request to choose an action for the board state `state`.
- start_ready  output  1  high only in IDLE.
- state  input  18  board, 2 bits per cell; cell k (action k, 1..9) is state[2k-1:2k-2]; 2'b00 means empty.
- epsilon  input  16  unsigned exploration threshold.
- q_rd_en  output  1  Q-table read strobe.
- q_rd_addr  output  18  latched board state.
- q_rd_sel  output  4  action table being read, 1..9.
- q_rd_data  input  16  signed two's-complement Q value, valid exactly one cycle after q_rd_en.
- act_valid  output  1  result valid.
- act_ready  input  1  consumer accepts result.
- action  output  4  chosen cell 1..9; 0 when no_move.
- q_best  output  16  greatest legal Q value (signed).
- explored  output  1  action came from the random path.
- no_move  output  1  board has no empty cell.
REQ-003 One clock; reset is asynchronous and active-low (clock, reset_n).

Function
REQ-004 FSM states IDLE, SCAN, DECIDE, EXPLORE, HOLD; start handshake completes when start_valid and start_ready are both high.
REQ-005 The accept edge latches state and epsilon and sets legal mask bit k when cell k equals 2'b00; 2'b01, 2'b10 and 2'b11 are occupied.
REQ-006 SCAN: cycles 1..9 after accept assert q_rd_en with q_rd_sel = 1..9 in order; q_rd_addr holds the latched state.
REQ-007 q_rd_data is sampled in cycles 2..10; only legal cells enter the signed running max; a strict greater-than compare makes the lowest index win ties.
REQ-008 DECIDE (cycle 11):
- no legal cell: no_move=1, action=0, q_best=0, explored=0, go to HOLD.
- otherwise, if lfsr < epsilon (unsigned), go to EXPLORE.
- otherwise, action = greedy index, go to HOLD.
REQ-009 EXPLORE:
- r = lfsr[3:0] captured in DECIDE, minus 9 if r >= 9.
- Candidate index starts at r+1; each cycle, if the candidate is legal, select it, set explored=1, go to HOLD.
- Otherwise increment the candidate, wrapping 9 to 1; at most 9 cycles.
REQ-010 q_best is always the greedy maximum, including when explored=1.
REQ-011 HOLD:
- act_valid=1; action, q_best, explored and no_move are stable while act_ready is low.
- act_valid and act_ready both high returns the FSM to IDLE; act_valid drops the next cycle.
REQ-012 Greedy latency: act_valid is first high in cycle 11 after accept. EXPLORE adds 1..9 cycles.
REQ-013 start_valid outside IDLE is ignored and has no side effects.
REQ-014 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advances every clock cycle regardless of FSM state.
REQ-015 Outputs are registered.

Reset
REQ-016 reset_n low forces, immediately and asynchronously:
- FSM to IDLE; LFSR to LFSR_SEED.
- outputs low: q_rd_en, act_valid, action, q_best, explored, no_move, q_rd_sel, q_rd_addr.
- start_ready high.
REQ-017 Reset mid-SCAN or mid-HOLD discards the request; no act_valid is produced for it.

Structure
REQ-018 Shared package qlearn_pkg holds Q_W=16, STATE_W=18, ACT_W=4, NUM_ACT=9, CELL_EMPTY=2'b00 and the FSM state type.
REQ-019 One sub-module, lfsr16, with ports clock, reset_n, seed and value.

Verification
REQ-020 Empty board (state=0), Q[k]=k*16'h0100, epsilon=0 -> act_valid in cycle 11, action=9, q_best=16'h0900, explored=0.
REQ-021 Cells 9 (01) and 8 (10) occupied, same Q, epsilon=0 -> action=7, q_best=16'h0700; q_rd_en still strobes all 9 tables.
REQ-022 Tie and negative cases, epsilon=0:
- all Q=16'h0200 -> action=1.
- Q[k]=-k -> action=1, q_best=16'hFFFF.
REQ-023 Full board (all cells 01/10) -> cycle 11 act_valid, no_move=1, action=0, q_best=0.
REQ-024 epsilon=16'hFFFF, only cells 3 and 6 empty -> explored=1, action in {3,6}, matching a reference LFSR model seeded 16'hACE1.
REQ-025 Backpressure and reset:
- act_ready low 5 cycles -> outputs stable; start_valid pulsed in HOLD is ignored.
- reset_n low in cycle 5 of SCAN -> q_rd_en=0 at once, no act_valid afterwards.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared constants, FSM state type and board helpers for the Q-learning
// action selector.
package qlearn_pkg;

    localparam int Q_W     = 16;
    localparam int STATE_W = 18;
    localparam int ACT_W   = 4;
    localparam int NUM_ACT = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DECIDE,
        EXPLORE,
        HOLD
    } sel_state_t;

    // Bit k is set when cell k (1..NUM_ACT) of the board is empty.
    function automatic logic [NUM_ACT:1] empty_cells(input logic [STATE_W-1:0] board);
        logic [NUM_ACT:1] mask;
        mask = '0;
        for (int k = 1; k <= NUM_ACT; k++) begin
            mask[k] = (board[2*k-1 -: 2] == CELL_EMPTY);
        end
        return mask;
    endfunction

endpackage

// File: rtl/action_selector_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1,
// used as the exploration random source.
module lfsr16 (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    localparam logic [15:0] TAPS = 16'hB400;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= seed;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/action_selector.sv
// Epsilon-greedy action selector: scans the nine Q tables for the latched
// board, keeps the greatest legal Q value, then either picks it or explores.
module action_selector
    import qlearn_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [STATE_W-1:0] state,
    input  logic [Q_W-1:0]     epsilon,
    output logic               q_rd_en,
    output logic [STATE_W-1:0] q_rd_addr,
    output logic [ACT_W-1:0]   q_rd_sel,
    input  logic [Q_W-1:0]     q_rd_data,
    output logic               act_valid,
    input  logic               act_ready,
    output logic [ACT_W-1:0]   action,
    output logic [Q_W-1:0]     q_best,
    output logic               explored,
    output logic               no_move
);

    localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(NUM_ACT);

    sel_state_t         fsm_q, fsm_d;
    logic [Q_W-1:0]     eps_q, eps_d;
    logic [NUM_ACT:1]   legal_q, legal_d;
    logic               pend_q, pend_d;
    logic [ACT_W-1:0]   pend_sel_q, pend_sel_d;
    logic               found_q, found_d;
    logic [Q_W-1:0]     best_val_q, best_val_d;
    logic [ACT_W-1:0]   best_idx_q, best_idx_d;
    logic [ACT_W-1:0]   cand_q, cand_d;
    logic               rd_en_d;
    logic [STATE_W-1:0] rd_addr_d;
    logic [ACT_W-1:0]   rd_sel_d;
    logic               act_valid_d;
    logic [ACT_W-1:0]   action_d;
    logic [Q_W-1:0]     q_best_d;
    logic               explored_d;
    logic               no_move_d;
    logic [ACT_W-1:0]   explore_r;
    logic [15:0]        lfsr_value;

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .value   (lfsr_value)
    );

    // Read data lags the strobe by one cycle, so pend/pend_sel remember
    // which table the current q_rd_data belongs to.
    always_comb begin
        fsm_d       = fsm_q;
        eps_d       = eps_q;
        legal_d     = legal_q;
        pend_d      = q_rd_en;
        pend_sel_d  = q_rd_sel;
        found_d     = found_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        cand_d      = cand_q;
        rd_en_d     = q_rd_en;
        rd_addr_d   = q_rd_addr;
        rd_sel_d    = q_rd_sel;
        act_valid_d = act_valid;
        action_d    = action;
        q_best_d    = q_best;
        explored_d  = explored;
        no_move_d   = no_move;

        explore_r = lfsr_value[ACT_W-1:0];
        if (explore_r >= LAST_ACT) begin
            explore_r = explore_r - LAST_ACT;
        end

        case (fsm_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    rd_addr_d   = state;
                    eps_d       = epsilon;
                    legal_d     = empty_cells(state);
                    found_d     = 1'b0;
                    best_val_d  = '0;
                    best_idx_d  = '0;
                    rd_en_d     = 1'b1;
                    rd_sel_d    = 4'd1;
                    action_d    = '0;
                    q_best_d    = '0;
                    explored_d  = 1'b0;
                    no_move_d   = 1'b0;
                    fsm_d       = SCAN;
                end
            end
            SCAN: begin
                if (q_rd_en) begin
                    if (q_rd_sel == LAST_ACT) begin
                        rd_en_d  = 1'b0;
                        rd_sel_d = '0;
                    end else begin
                        rd_sel_d = q_rd_sel + 4'd1;
                    end
                end
                // Strict compare keeps the lowest index on ties.
                if (pend_q) begin
                    if (legal_q[pend_sel_q] &&
                        (!found_q || ($signed(q_rd_data) > $signed(best_val_q)))) begin
                        found_d    = 1'b1;
                        best_val_d = q_rd_data;
                        best_idx_d = pend_sel_q;
                    end
                    if (pend_sel_q == LAST_ACT) begin
                        fsm_d = DECIDE;
                    end
                end
            end
            DECIDE: begin
                if (!found_q) begin
                    no_move_d   = 1'b1;
                    action_d    = '0;
                    q_best_d    = '0;
                    explored_d  = 1'b0;
                    act_valid_d = 1'b1;
                    fsm_d       = HOLD;
                end else begin
                    q_best_d = best_val_q;
                    if (lfsr_value < eps_q) begin
                        cand_d = explore_r + 4'd1;
                        fsm_d  = EXPLORE;
                    end else begin
                        action_d    = best_idx_q;
                        act_valid_d = 1'b1;
                        fsm_d       = HOLD;
                    end
                end
            end
            EXPLORE: begin
                if (legal_q[cand_q]) begin
                    action_d    = cand_q;
                    explored_d  = 1'b1;
                    act_valid_d = 1'b1;
                    fsm_d       = HOLD;
                end else begin
                    cand_d = (cand_q == LAST_ACT) ? 4'd1 : cand_q + 4'd1;
                end
            end
            HOLD: begin
                if (act_ready) begin
                    act_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            eps_q       <= '0;
            legal_q     <= '0;
            pend_q      <= 1'b0;
            pend_sel_q  <= '0;
            found_q     <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            cand_q      <= '0;
            start_ready <= 1'b1;
            q_rd_en     <= 1'b0;
            q_rd_addr   <= '0;
            q_rd_sel    <= '0;
            act_valid   <= 1'b0;
            action      <= '0;
            q_best      <= '0;
            explored    <= 1'b0;
            no_move     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            eps_q       <= eps_d;
            legal_q     <= legal_d;
            pend_q      <= pend_d;
            pend_sel_q  <= pend_sel_d;
            found_q     <= found_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            cand_q      <= cand_d;
            start_ready <= (fsm_d == IDLE);
            q_rd_en     <= rd_en_d;
            q_rd_addr   <= rd_addr_d;
            q_rd_sel    <= rd_sel_d;
            act_valid   <= act_valid_d;
            action      <= action_d;
            q_best      <= q_best_d;
            explored    <= explored_d;
            no_move     <= no_move_d;
        end
    end

endmodule

// File: tb/tb_action_selector.sv
// Self-checking bench for action_selector: directed vector table, exploration
// and reset sequences, then randomized transactions against a reference model.
module tb_action_selector;

    logic        clock;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [17:0] state;
    logic [15:0] epsilon;
    logic        q_rd_en;
    logic [17:0] q_rd_addr;
    logic [3:0]  q_rd_sel;
    logic [15:0] q_rd_data;
    logic        act_valid;
    logic        act_ready;
    logic [3:0]  action;
    logic [15:0] q_best;
    logic        explored;
    logic        no_move;

    typedef struct {
        logic [3:0]  action;
        logic [15:0] q_best;
        logic        explored;
        logic        no_move;
        int          latency;
    } result_t;

    typedef struct {
        logic [17:0] board;
        int          qmode;
        logic [3:0]  action;
        logic [15:0] q_best;
        logic        no_move;
        int          hold;
    } vec_t;

    int          total_count = 0;
    int          pass_count  = 0;
    int unsigned edge_count;
    logic [15:0] q_table [0:15];

    action_selector #(.LFSR_SEED(16'hACE1)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .state       (state),
        .epsilon     (epsilon),
        .q_rd_en     (q_rd_en),
        .q_rd_addr   (q_rd_addr),
        .q_rd_sel    (q_rd_sel),
        .q_rd_data   (q_rd_data),
        .act_valid   (act_valid),
        .act_ready   (act_ready),
        .action      (action),
        .q_best      (q_best),
        .explored    (explored),
        .no_move     (no_move)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Q-table memory: data appears one cycle after the strobe.
    always @(posedge clock) begin
        if (q_rd_en) q_rd_data <= q_table[q_rd_sel];
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_count <= 0;
        else          edge_count <= edge_count + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // LFSR value after n clock edges from the seed, built from the polynomial exponents.
    function automatic logic [15:0] lfsr_after(input int unsigned n);
        logic [15:0] v;
        logic [15:0] mask;
        int exps[4];
        exps = '{16, 14, 13, 11};
        mask = '0;
        foreach (exps[i]) mask[exps[i]-1] = 1'b1;
        v = 16'hACE1;
        for (int unsigned s = 0; s < n; s++) v = v[0] ? ((v >> 1) ^ mask) : (v >> 1);
        return v;
    endfunction

    function automatic bit cell_empty(input logic [17:0] board, input int k);
        return ((board >> (2*k - 2)) & 18'h3) == 18'h0;
    endfunction

    function automatic result_t reference(input logic [17:0] board, input logic [15:0] eps,
                                          input logic [15:0] rnd);
        result_t res;
        int best_k;
        int best_v;
        int v;
        int r;
        int c;
        res.action = 0; res.q_best = 0; res.explored = 0; res.no_move = 0; res.latency = 11;
        best_k = 0;
        best_v = 0;
        for (int k = 1; k <= 9; k++) begin
            if (cell_empty(board, k)) begin
                v = int'($signed(q_table[k]));
                if (best_k == 0 || v > best_v) begin
                    best_k = k;
                    best_v = v;
                end
            end
        end
        if (best_k == 0) begin
            res.no_move = 1;
            return res;
        end
        res.q_best = best_v[15:0];
        if (rnd < eps) begin
            r = (int'(rnd) % 16) % 9;
            for (int t = 1; t <= 9; t++) begin
                c = (r + t - 1) % 9 + 1;
                if (cell_empty(board, c)) begin
                    res.action   = c[3:0];
                    res.explored = 1;
                    res.latency  = 11 + t;
                    break;
                end
            end
        end else begin
            res.action = best_k[3:0];
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic setQTable(input int mode);
        for (int k = 0; k < 16; k++) q_table[k] = 16'h0000;
        for (int k = 1; k <= 9; k++) begin
            case (mode)
                0:       q_table[k] = 16'(k * 256);
                1:       q_table[k] = 16'h0200;
                2:       q_table[k] = 16'(-k);
                default: q_table[k] = 16'($urandom);
            endcase
        end
    endtask

    task automatic applyStimulus(input logic [17:0] board, input logic [15:0] eps,
                                 input bit use_model, input result_t exp_in,
                                 input int hold_cycles, input bit poke_start,
                                 output logic [3:0] got_action);
        result_t     exp;
        int          waited;
        int          first;
        int          strobe_errs;
        int          stable_errs;
        int unsigned ec0;
        got_action = 4'hF;
        waited = 0;
        @(negedge clock);
        while (!start_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("start_ready", 32'(start_ready), 32'd1);
        state       = board;
        epsilon     = eps;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        ec0 = edge_count;
        exp = use_model ? reference(board, eps, lfsr_after(ec0 + 10)) : exp_in;
        strobe_errs = 0;
        first = -1;
        for (int n = 0; n <= 40 && first < 0; n++) begin
            if (n > 0) begin
                @(posedge clock);
                #1;
            end
            if (n <= 8) begin
                if (!(q_rd_en === 1'b1 && q_rd_sel === 4'(n + 1) && q_rd_addr === board)) strobe_errs++;
            end else if (q_rd_en !== 1'b0) begin
                strobe_errs++;
            end
            if (act_valid === 1'b1) first = n;
        end
        checkOutput("rd_strobe", 32'(strobe_errs), 32'd0);
        checkOutput("latency", 32'(first), 32'(exp.latency));
        if (first >= 0) begin
            got_action = action;
            checkOutput("action", 32'(action), 32'(exp.action));
            checkOutput("q_best", 32'(q_best), 32'(exp.q_best));
            checkOutput("explored", 32'(explored), 32'(exp.explored));
            checkOutput("no_move", 32'(no_move), 32'(exp.no_move));
            stable_errs = 0;
            for (int h = 0; h < hold_cycles; h++) begin
                if (poke_start && h == 0) start_valid = 1'b1;
                @(posedge clock);
                #1;
                start_valid = 1'b0;
                if (act_valid !== 1'b1 || action !== exp.action || q_best !== exp.q_best ||
                    explored !== exp.explored || no_move !== exp.no_move ||
                    start_ready !== 1'b0 || q_rd_addr !== board || q_rd_en !== 1'b0) stable_errs++;
            end
            if (hold_cycles > 0) checkOutput("hold_stable", 32'(stable_errs), 32'd0);
            act_ready = 1'b1;
            @(posedge clock);
            #1;
            act_ready = 1'b0;
            checkOutput("release", {30'd0, act_valid, start_ready}, 32'd1);
        end
    endtask

    vec_t        vecs[10];
    result_t     exp_r;
    result_t     dummy;
    logic [3:0]  got;
    logic [17:0] rb;
    logic [15:0] re;
    int          seen;

    initial begin
        reset_n     = 1'b0;
        start_valid = 1'b0;
        act_ready   = 1'b0;
        state       = '0;
        epsilon     = '0;
        setQTable(0);
        dummy.action = 0; dummy.q_best = 0; dummy.explored = 0; dummy.no_move = 0; dummy.latency = 0;

        repeat (3) @(negedge clock);
        checkOutput("reset_ready", 32'(start_ready), 32'd1);
        checkOutput("reset_outputs", {23'd0, q_rd_en, act_valid, explored, no_move, action},
                    32'd0);
        checkOutput("reset_rd", {10'd0, q_rd_sel, q_rd_addr}, 32'd0);
        checkOutput("reset_q_best", 32'(q_best), 32'd0);
        reset_n = 1'b1;

        vecs[0] = '{18'h00000, 0, 4'd9, 16'h0900, 1'b0, 5};
        vecs[1] = '{18'h18000, 0, 4'd7, 16'h0700, 1'b0, 0};
        vecs[2] = '{18'h00000, 1, 4'd1, 16'h0200, 1'b0, 1};
        vecs[3] = '{18'h00000, 2, 4'd1, 16'hFFFF, 1'b0, 0};
        vecs[4] = '{18'h15555, 0, 4'd0, 16'h0000, 1'b1, 2};
        vecs[5] = '{18'h3FFFF, 2, 4'd0, 16'h0000, 1'b1, 0};
        vecs[6] = '{18'h3FCFF, 0, 4'd5, 16'h0500, 1'b0, 0};
        vecs[7] = '{18'h00001, 2, 4'd2, 16'hFFFE, 1'b0, 0};
        vecs[8] = '{18'h2AAAA, 1, 4'd0, 16'h0000, 1'b1, 0};
        vecs[9] = '{18'h00005, 1, 4'd3, 16'h0200, 1'b0, 3};

        for (int i = 0; i < 10; i++) begin
            setQTable(vecs[i].qmode);
            exp_r.action   = vecs[i].action;
            exp_r.q_best   = vecs[i].q_best;
            exp_r.explored = 1'b0;
            exp_r.no_move  = vecs[i].no_move;
            exp_r.latency  = 11;
            applyStimulus(vecs[i].board, 16'h0000, 1'b0, exp_r, vecs[i].hold, vecs[i].hold > 0, got);
        end

        // Exploration with only cells 3 and 6 empty.
        setQTable(0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(18'h15145, 16'hFFFF, 1'b1, dummy, i, 1'b0, got);
            checkOutput("explore_set", 32'(got == 4'd3 || got == 4'd6), 32'd1);
        end

        // Reset in the middle of SCAN.
        @(negedge clock);
        state = 18'h00000;
        epsilon = 16'h0000;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        checkOutput("scan_busy", 32'(q_rd_en), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_scan_rd_en", 32'(q_rd_en), 32'd0);
        checkOutput("rst_scan_ready", 32'(start_ready), 32'd1);
        checkOutput("rst_scan_rd", {10'd0, q_rd_sel, q_rd_addr}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (act_valid !== 1'b0 || q_rd_en !== 1'b0) seen++;
        end
        checkOutput("rst_scan_quiet", 32'(seen), 32'd0);

        // Reset while holding a result.
        @(negedge clock);
        state = 18'h00000;
        start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        seen = 0;
        for (int n = 1; n <= 20 && seen == 0; n++) begin
            @(posedge clock);
            #1;
            if (act_valid === 1'b1) seen = n;
        end
        checkOutput("hold_reached", 32'(seen), 32'd11);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_hold_outputs", {16'd0, act_valid, explored, no_move, action, 9'd0}, 32'd0);
        checkOutput("rst_hold_q_best", 32'(q_best), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clock);
            #1;
            if (act_valid !== 1'b0) seen++;
        end
        checkOutput("rst_hold_quiet", 32'(seen), 32'd0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            setQTable(3);
            rb = '0;
            for (int k = 0; k < 9; k++) begin
                if ($urandom_range(0, 1) == 1) rb[2*k +: 2] = 2'($urandom_range(1, 3));
            end
            case ($urandom_range(0, 2))
                0:       re = 16'h0000;
                1:       re = 16'hFFFF;
                default: re = 16'($urandom);
            endcase
            applyStimulus(rb, re, 1'b1, dummy, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
